// File: rtl/cadd_arbiter.sv
// cadd_arbiter: round-robin arbiter sharing one complex adder among NUM_REQ
// requesters. The granted operand pair is summed by cadd and captured in a
// one-entry output slot tagged with the requester index.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid / req_ready   per-requester handshake (ready is one-hot or zero)
//   req_ar/ai/br/bi         packed S3.4 operands, requester i at [i*W +: W]
//   out_valid / out_ready   result slot handshake
//   out_pr, out_pi          signed sum, one bit wider than the operands
//   out_tag                 index of the requester that produced the sum
//   perf_done, perf_stall   saturating counters, present only when
//                           CADD_ARB_PERF_EN is defined
//
// Widths normally come from fixed_point_params.vh; defaults are provided
// here so the file stands alone.
//
// State | meaning
// ------+----------------------------
// IDLE  | output slot empty
// FULL  | output slot holds a result

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif
`ifndef ADD_WIDTH
`define ADD_WIDTH 9
`endif

module cadd #(
   parameter int W  = `TOTAL_WIDTH,
   parameter int AW = `ADD_WIDTH
) (
   input  logic [W-1:0]  i_ar,
   input  logic [W-1:0]  i_ai,
   input  logic [W-1:0]  i_br,
   input  logic [W-1:0]  i_bi,
   output logic [AW-1:0] o_pr,
   output logic [AW-1:0] o_pi
);
   // sign-extend before adding so the full sum range fits without wrap
   assign o_pr = {{(AW-W){i_ar[W-1]}}, i_ar} + {{(AW-W){i_br[W-1]}}, i_br};
   assign o_pi = {{(AW-W){i_ai[W-1]}}, i_ai} + {{(AW-W){i_bi[W-1]}}, i_bi};
endmodule

module cadd_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int TAG_WIDTH = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*`TOTAL_WIDTH-1:0] req_ar,
   input  logic [NUM_REQ*`TOTAL_WIDTH-1:0] req_ai,
   input  logic [NUM_REQ*`TOTAL_WIDTH-1:0] req_br,
   input  logic [NUM_REQ*`TOTAL_WIDTH-1:0] req_bi,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [`ADD_WIDTH-1:0]           out_pr,
   output logic [`ADD_WIDTH-1:0]           out_pi,
   output logic [TAG_WIDTH-1:0]            out_tag
`ifdef CADD_ARB_PERF_EN
   ,
   output logic [15:0]                     perf_done,
   output logic [15:0]                     perf_stall
`endif
);
   localparam int TW = `TOTAL_WIDTH;

   typedef enum logic {ST_IDLE, ST_FULL} state_t;

   state_t                 r_state, w_state_nxt;
   logic [TAG_WIDTH-1:0]   r_rr_ptr;
   logic [TAG_WIDTH-1:0]   w_gidx;
   logic                   w_found;
   logic                   w_can_accept;
   logic [NUM_REQ-1:0]     w_grant;
   logic                   w_xfer;
   logic [TW-1:0]          w_ar, w_ai, w_br, w_bi;
   logic [`ADD_WIDTH-1:0]  w_pr, w_pi;

   assign w_can_accept = (r_state == ST_IDLE) | out_ready;

   // first valid requester at or after the round-robin pointer
   always_comb begin
      int idx;
      w_gidx  = '0;
      w_found = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_gidx  = TAG_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (w_found && w_can_accept) w_grant[w_gidx] = 1'b1;
   end

   // rst_n gate keeps ready low while reset is held even though IDLE accepts
   assign req_ready = w_grant & {NUM_REQ{rst_n}};
   assign w_xfer    = |(req_ready & req_valid);

   assign w_ar = req_ar[int'(w_gidx)*TW +: TW];
   assign w_ai = req_ai[int'(w_gidx)*TW +: TW];
   assign w_br = req_br[int'(w_gidx)*TW +: TW];
   assign w_bi = req_bi[int'(w_gidx)*TW +: TW];

   cadd #(.W(TW), .AW(`ADD_WIDTH)) u_cadd (
      .i_ar (w_ar),
      .i_ai (w_ai),
      .i_br (w_br),
      .i_bi (w_bi),
      .o_pr (w_pr),
      .o_pi (w_pi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_xfer) w_state_nxt = ST_FULL;
         ST_FULL: if (out_ready && !w_xfer) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pr   <= '0;
         out_pi   <= '0;
         out_tag  <= '0;
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         out_pr  <= w_pr;
         out_pi  <= w_pi;
         out_tag <= w_gidx;
         if (w_gidx == TAG_WIDTH'(NUM_REQ-1)) r_rr_ptr <= '0;
         else                                 r_rr_ptr <= w_gidx + 1'b1;
      end
   end

   assign out_valid = (r_state == ST_FULL);

`ifdef CADD_ARB_PERF_EN
   logic [15:0] r_perf_done, r_perf_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_done  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (out_valid && out_ready && r_perf_done != 16'hFFFF)
            r_perf_done <= r_perf_done + 16'd1;
         // one count per cycle in which at least one valid requester waits
         if ((|(req_valid & ~req_ready)) && r_perf_stall != 16'hFFFF)
            r_perf_stall <= r_perf_stall + 16'd1;
      end
   end

   assign perf_done  = r_perf_done;
   assign perf_stall = r_perf_stall;
`endif
endmodule
